// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg -- constants shared between the DMA engine, its interface and
// the parent that owns the RAM.
//   mode_e       : transfer mode encoding (copy = 0, fill = 1)
//   addr_width() : RAM address width for a RAM of the given size in KiB
package ram_dma_pkg;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_e;

    function automatic int addr_width(input int kb);
        return $clog2(kb * 1024);
    endfunction

endpackage

// File: rtl/ram_dma_if.sv
// ram_dma_if -- command, status and RAM-port bundle of the DMA engine.
//   start/mode/src/dst/len/fill : transfer request from the parent
//   busy/done                   : transfer status back to the parent
//   a/d/w                       : RAM address, write data, write enable
//   q                           : RAM read data (registered, one cycle after a)
// The slave modport is the DMA engine; the master modport is the parent that
// issues requests and owns the RAM.
interface ram_dma_if #(
    parameter int KB = 16
);
    import ram_dma_pkg::*;

    localparam int AW = addr_width(KB);

    logic          start;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [7:0]    fill;
    logic          busy;
    logic          done;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          w;
    logic [7:0]    q;

    modport slave (
        input  start, mode, src, dst, len, fill, q,
        output busy, done, a, d, w
    );

    modport master (
        output start, mode, src, dst, len, fill, q,
        input  busy, done, a, d, w
    );

endinterface

// File: rtl/ram_dma.sv
// ram_dma -- single-channel byte DMA into an externally instantiated RAM.
// Copy moves len bytes from src to dst in ascending order (read cycle then
// write cycle per byte); fill writes the latched fill byte to len bytes at dst
// one byte per cycle. Pointers wrap modulo the RAM size.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : ram_dma_if slave (request, status and RAM port)
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int KB = 16
) (
    input  logic     clock,
    input  logic     reset,
    ram_dma_if.slave bus
);

    localparam int AW = addr_width(KB);

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e        state_r;
    state_e        state_s;
    logic [AW-1:0] src_ptr_r;
    logic [AW-1:0] dst_ptr_r;
    logic [AW:0]   count_r;
    logic [7:0]    fill_r;
    logic          last_s;

    // Last byte of the transfer is being handled this cycle.
    assign last_s = (count_r == CNT_ONE);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. The request mode is captured by the state entered
    // (READ for copy, FILL for fill), so no separate mode register is kept.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len == CNT_ZERO) begin
                        state_s = ST_DONE;
                    end else if (mode_e'(bus.mode) == MODE_FILL) begin
                        state_s = ST_FILL;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_FILL: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request capture, pointer advance and byte countdown.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_ptr_r <= {AW{1'b0}};
            dst_ptr_r <= {AW{1'b0}};
            count_r   <= CNT_ZERO;
            fill_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        src_ptr_r <= bus.src;
                        dst_ptr_r <= bus.dst;
                        count_r   <= bus.len;
                        fill_r    <= bus.fill;
                    end
                end
                ST_WRITE: begin
                    src_ptr_r <= src_ptr_r + PTR_ONE;
                    dst_ptr_r <= dst_ptr_r + PTR_ONE;
                    count_r   <= count_r - CNT_ONE;
                end
                ST_FILL: begin
                    dst_ptr_r <= dst_ptr_r + PTR_ONE;
                    count_r   <= count_r - CNT_ONE;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Moore output decode. In WRITE the RAM read data returned for the
    // address presented in READ is forwarded straight to the write port.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.a    = {AW{1'b0}};
        bus.d    = 8'h00;
        bus.w    = 1'b0;
        case (state_r)
            ST_READ: begin
                bus.busy = 1'b1;
                bus.a    = src_ptr_r;
            end
            ST_WRITE: begin
                bus.busy = 1'b1;
                bus.a    = dst_ptr_r;
                bus.d    = bus.q;
                bus.w    = 1'b1;
            end
            ST_FILL: begin
                bus.busy = 1'b1;
                bus.a    = dst_ptr_r;
                bus.d    = fill_r;
                bus.w    = 1'b1;
            end
            ST_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma -- bench for ram_dma with a 1 KiB RAM pre-loaded with
// mem[i] = i[7:0]. A byte-array reference memory is updated with the plain
// meaning of each transfer and compared against the RAM after every run,
// together with per-transfer timing, write-enable pattern and addresses.
module tb_ram_dma;

    localparam int KB = 1;
    localparam int N  = 1024;

    logic clock;
    logic reset;
    logic preload;
    int   chk_cnt;
    int   pass_cnt;

    logic [7:0] mem     [0:N-1];
    logic [7:0] ref_mem [0:N-1];

    ram_dma_if #(.KB(KB)) bus ();

    ram_dma #(.KB(KB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM: registered read, write on w.
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < N; i++) mem[i] <= 8'(i);
        end else begin
            if (bus.w) mem[bus.a] <= bus.d;
            bus.q <= mem[bus.a];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs === exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        check_val(tag, diffs, 0);
    endtask

    // Run one transfer; with poke set, start is also pulsed mid-transfer and
    // during the done cycle with different parameters, which must be ignored.
    task automatic run_xfer(input string tag, input bit m, input int s, input int dd,
                            input int n, input logic [7:0] f, input bit poke);
        int  busy_n;
        int  w_n;
        bit  seen_done;
        bit  wpat_ok;
        bit  addr_ok;
        bit  exp_w;

        for (int i = 0; i < n; i++) begin
            if (m) ref_mem[(dd + i) % N] = f;
            else   ref_mem[(dd + i) % N] = ref_mem[(s + i) % N];
        end

        bus.mode  = m;
        bus.src   = 10'(s);
        bus.dst   = 10'(dd);
        bus.len   = 11'(n);
        bus.fill  = f;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;

        busy_n = 0; w_n = 0; seen_done = 1'b0; wpat_ok = 1'b1; addr_ok = 1'b1;
        for (int c = 0; c < 2 * n + 4; c++) begin
            if (bus.done) begin
                seen_done = 1'b1;
                break;
            end
            if (bus.busy) begin
                exp_w = m ? 1'b1 : ((busy_n % 2) == 1);
                if (bus.w !== exp_w) wpat_ok = 1'b0;
                if (bus.w) begin
                    if (bus.a !== 10'(dd + w_n)) addr_ok = 1'b0;
                    w_n++;
                end else if (bus.a !== 10'(s + busy_n / 2)) begin
                    addr_ok = 1'b0;
                end
                busy_n++;
            end else begin
                wpat_ok = 1'b0;
            end
            if (poke && busy_n == 1) begin
                bus.mode  = ~m;
                bus.dst   = 10'(dd + 7);
                bus.len   = 11'd5;
                bus.fill  = ~f;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clock);
        end

        check_val({tag, "_done_seen"}, seen_done, 1);
        check_val({tag, "_busy_cycles"}, busy_n, m ? n : 2 * n);
        check_val({tag, "_writes"}, w_n, n);
        check_val({tag, "_wpattern"}, wpat_ok, 1);
        check_val({tag, "_addr"}, addr_ok, 1);

        if (poke) begin
            bus.mode  = 1'b1;
            bus.dst   = 10'(dd + 11);
            bus.len   = 11'd3;
            bus.start = 1'b1;
        end
        @(negedge clock);
        bus.start = 1'b0;
        check_val({tag, "_done_width"}, {bus.done, bus.busy}, 0);
        check_val({tag, "_idle_outs"}, {bus.w, bus.a, bus.d}, 0);
        if (poke) begin
            @(negedge clock);
            check_val({tag, "_still_idle"}, {bus.busy, bus.done}, 0);
        end
        check_mem({tag, "_mem"});
    endtask

    initial begin
        int wc;
        bit bad;

        chk_cnt = 0; pass_cnt = 0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
        bus.len = '0; bus.fill = 8'h00;
        for (int i = 0; i < N; i++) ref_mem[i] = 8'(i);

        reset = 1'b0;
        preload = 1'b1;
        @(negedge clock);
        check_val("reset_outs", {bus.busy, bus.done, bus.w, bus.a, bus.d}, 0);
        @(negedge clock);
        preload = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_val("idle_after_reset", {bus.busy, bus.done, bus.w}, 0);
        check_mem("preload_mem");

        // Directed cases.
        run_xfer("fill",   1'b1, 0,      10'h100, 4, 8'hA5, 1'b0);
        run_xfer("copy",   1'b0, 10'h010, 10'h200, 3, 8'h00, 1'b0);
        run_xfer("wrap",   1'b1, 0,      10'h3FE, 4, 8'h5A, 1'b0);
        run_xfer("len0",   1'b1, 0,      10'h080, 0, 8'h77, 1'b0);
        run_xfer("len0c",  1'b0, 10'h020, 10'h090, 0, 8'h00, 1'b0);
        run_xfer("ignore", 1'b0, 10'h040, 10'h240, 2, 8'h00, 1'b1);
        run_xfer("ovl",    1'b0, 10'h050, 10'h051, 6, 8'h00, 1'b0);
        run_xfer("cwrap",  1'b0, 10'h3FD, 10'h001, 5, 8'h00, 1'b0);

        // Reset in the middle of a copy, after three bytes have been written.
        run_xfer("prep", 1'b1, 0, 10'h300, 16, 8'hEE, 1'b0);
        bus.mode = 1'b0; bus.src = 10'h000; bus.dst = 10'h300; bus.len = 11'd8;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wc = 0;
        for (int c = 0; c < 40 && wc < 3; c++) begin
            if (bus.w) wc++;
            if (wc < 3) @(negedge clock);
        end
        check_val("rst_write_count", wc, 3);
        @(posedge clock);
        #1 reset = 1'b0;
        #1 check_val("rst_outs_zero", {bus.busy, bus.done, bus.w, bus.a, bus.d}, 0);
        for (int i = 0; i < 3; i++) ref_mem[10'h300 + i] = ref_mem[i];
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (bus.done || bus.w || bus.busy) bad = 1'b1;
        end
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (bus.done || bus.w || bus.busy) bad = 1'b1;
        end
        check_val("rst_quiet", bad, 0);
        check_mem("rst_mem");

        // Randomized transfers.
        for (int t = 0; t < 24; t++) begin
            int n;
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 20));
            run_xfer("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                     int'($urandom_range(0, N - 1)), n, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Full-size transfers.
        run_xfer("fullcopy", 1'b0, 10'h123, 10'h2C7, N, 8'h00, 1'b0);
        run_xfer("fullfill", 1'b1, 0,      10'h155, N, 8'h3C, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
